// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and helpers for the scoreboarded register file
package regfile_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREG  = 32;

    // Helpers are sized for the widest legal instance; callers cast in and out.
    localparam int MAX_WIDTH = 512;
    localparam int MAX_BYTES = MAX_WIDTH / 8;
    localparam int MAX_ADDRW = 6;

    function automatic logic [MAX_WIDTH-1:0] byte_merge(
        input logic [MAX_WIDTH-1:0] old_val,
        input logic [MAX_WIDTH-1:0] new_val,
        input logic [MAX_BYTES-1:0] mask
    );
        logic [MAX_WIDTH-1:0] merged;
        merged = old_val;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (mask[b]) begin
                merged[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return merged;
    endfunction

    function automatic logic bypass_hit(
        input logic                 write_eff,
        input logic [MAX_ADDRW-1:0] read_addr,
        input logic [MAX_ADDRW-1:0] write_addr
    );
        return write_eff && (read_addr == write_addr);
    endfunction

endpackage

// File: rtl/regfile_cell.sv
// rtl/regfile_cell.sv - one byte-enabled data register plus its busy flop
module regfile_cell #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [WIDTH/8-1:0] be,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               set,
    output logic [WIDTH-1:0]   data,
    output logic               busy
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            busy <= 1'b0;
        end else begin
            if (we) begin
                for (int b = 0; b < WIDTH/8; b++) begin
                    if (be[b]) begin
                        data[8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            // A reserve landing on the register being written back wins.
            if (set) begin
                busy <= 1'b1;
            end else if (we) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 2R/1W register file with busy scoreboard; REGFILE_BYPASS_EN adds write-to-read bypass
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NREG     = DEF_NREG,
    parameter int ADDRW    = $clog2(NREG),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                      Clk,
    input  logic                      ResetN,
    input  logic [ADDRW-1:0]          ReadRegister1,
    input  logic [ADDRW-1:0]          ReadRegister2,
    output logic [WIDTH-1:0]          ReadData1,
    output logic [WIDTH-1:0]          ReadData2,
    output logic                      ReadBusy1,
    output logic                      ReadBusy2,
    input  logic [ADDRW-1:0]          WriteRegister,
    input  logic [WIDTH-1:0]          WriteData,
    input  logic                      RegWrite,
    input  logic [WIDTH/8-1:0]        ByteEnable,
    input  logic [ADDRW-1:0]          ReserveRegister,
    input  logic                      Reserve,
    output logic                      ReserveStall,
    output logic [$clog2(NREG+1)-1:0] BusyCount
);

    localparam int CW = $clog2(NREG+1);

    logic [WIDTH-1:0] cell_data [NREG];
    logic [NREG-1:0]  cell_busy;

    logic wr_eff, rsv_hit, rsv_eff, same_reg, wr_busy, rsv_busy, inc, dec;

    // Addresses that map onto real, writable storage.
    function automatic logic addr_ok(input logic [ADDRW-1:0] a);
        return (32'(a) < NREG) && !(ZERO_REG && (a == '0));
    endfunction

    always_comb begin
        wr_eff       = RegWrite && addr_ok(WriteRegister);
        rsv_hit      = Reserve && addr_ok(ReserveRegister);
        same_reg     = (WriteRegister == ReserveRegister);
        wr_busy      = wr_eff && cell_busy[WriteRegister];
        rsv_busy     = rsv_hit && cell_busy[ReserveRegister];
        ReserveStall = rsv_busy && !(wr_eff && same_reg);
        rsv_eff      = rsv_hit && !ReserveStall;
        inc          = rsv_eff && !rsv_busy;
        dec          = wr_busy && !(rsv_eff && same_reg);
    end

    for (genvar i = 0; i < NREG; i++) begin : g_cell
        if (ZERO_REG && (i == 0)) begin : g_tie
            assign cell_data[i] = '0;
            assign cell_busy[i] = 1'b0;
        end else begin : g_reg
            regfile_cell #(.WIDTH(WIDTH)) u_cell (
                .clk   (Clk),
                .rst_n (ResetN),
                .we    (wr_eff && (WriteRegister == ADDRW'(i))),
                .be    (ByteEnable),
                .wdata (WriteData),
                .set   (rsv_eff && (ReserveRegister == ADDRW'(i))),
                .data  (cell_data[i]),
                .busy  (cell_busy[i])
            );
        end
    end

    always_comb begin
        ReadData1 = addr_ok(ReadRegister1) ? cell_data[ReadRegister1] : '0;
        ReadBusy1 = addr_ok(ReadRegister1) && cell_busy[ReadRegister1];
        ReadData2 = addr_ok(ReadRegister2) ? cell_data[ReadRegister2] : '0;
        ReadBusy2 = addr_ok(ReadRegister2) && cell_busy[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
        if (bypass_hit(wr_eff, MAX_ADDRW'(ReadRegister1), MAX_ADDRW'(WriteRegister))) begin
            ReadData1 = WIDTH'(byte_merge(MAX_WIDTH'(ReadData1), MAX_WIDTH'(WriteData),
                                          MAX_BYTES'(ByteEnable)));
            ReadBusy1 = rsv_eff && (ReserveRegister == ReadRegister1);
        end
        if (bypass_hit(wr_eff, MAX_ADDRW'(ReadRegister2), MAX_ADDRW'(WriteRegister))) begin
            ReadData2 = WIDTH'(byte_merge(MAX_WIDTH'(ReadData2), MAX_WIDTH'(WriteData),
                                          MAX_BYTES'(ByteEnable)));
            ReadBusy2 = rsv_eff && (ReserveRegister == ReadRegister2);
        end
`endif
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            BusyCount <= '0;
        end else begin
            BusyCount <= BusyCount + CW'(inc) - CW'(dec);
        end
    end

endmodule
